video_timing_gen: RTL and testbench



---
 rtl/video_timing_pkg.sv | 48 ++++
 rtl/video_timing_axis.sv | 71 +++++++
 rtl/video_timing_gen.sv | 117 +++++++++++
 tb/tb_video_timing_gen.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared raster constants and window/offset helpers for the video timing generator.
package video_timing_pkg;

    // Default DK-class 384x264 raster
    localparam int unsigned DEF_CLK_DIV    = 4;
    localparam int unsigned DEF_HCNT_W     = 9;
    localparam int unsigned DEF_H_TOTAL    = 384;
    localparam int unsigned DEF_H_BL_START = 256;
    localparam int unsigned DEF_H_BL_END   = 0;
    localparam int unsigned DEF_H_SY_START = 288;
    localparam int unsigned DEF_H_SY_END   = 320;
    localparam int unsigned DEF_V_INC_H    = 288;
    localparam int unsigned DEF_VCNT_W     = 9;
    localparam int unsigned DEF_V_FIRST    = 504;
    localparam int unsigned DEF_V_LAST     = 255;
    localparam int unsigned DEF_V_BL_START = 240;
    localparam int unsigned DEF_V_BL_END   = 16;
    localparam int unsigned DEF_V_SY_START = 504;
    localparam int unsigned DEF_V_SY_END   = 508;
    localparam int unsigned DEF_OFS_W      = 5;

    // x in [s,e), wrapping when s > e; s == e is an empty window
    function automatic logic in_window(input int unsigned x, input int unsigned s,
                                       input int unsigned e);
        if (s <= e) begin
            return (x >= s) && (x < e);
        end
        return (x >= s) || (x < e);
    endfunction

    // (a + ofs) reduced into 0..total-1 for any signed offset
    function automatic int unsigned mod_add(input int unsigned a, input int ofs,
                                            input int unsigned total);
        int r;
        r = (int'(a % total) + ofs) % int'(total);
        if (r < 0) begin
            r = r + int'(total);
        end
        return unsigned'(r);
    endfunction

    // Ordinal position of x in a ring that starts at first, modulo span
    function automatic int unsigned ring_idx(input int unsigned x, input int unsigned first,
                                             input int unsigned span);
        return (x + span - first) % span;
    endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: wrap counter FIRST..LAST plus registered blank/sync windows
// evaluated on the ring index of the value the counter is about to take.
module video_timing_axis
    import video_timing_pkg::*;
#(
    parameter int unsigned W        = 9,
    parameter int unsigned FIRST    = 0,
    parameter int unsigned LAST     = 383,
    parameter int unsigned BL_START = 256,
    parameter int unsigned BL_END   = 0,
    parameter int unsigned SY_START = 288,
    parameter int unsigned SY_END   = 320,
    parameter int unsigned OFS_W    = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    step_i,
    input  logic                    upd_i,
    input  logic signed [OFS_W-1:0] ofs_i,
    output logic [W-1:0]            cnt_o,
    output logic [W-1:0]            cnt_nxt_c_o,
    output logic                    blank_n_o,
    output logic                    blank_n_nxt_c_o,
    output logic                    sync_n_o
);

    localparam int unsigned SPAN = 32'd1 << W;
    localparam int unsigned LEN  = ring_idx(LAST, FIRST, SPAN) + 1;
    localparam int unsigned BL_S = ring_idx(BL_START, FIRST, SPAN);
    localparam int unsigned BL_E = ring_idx(BL_END, FIRST, SPAN);
    localparam int unsigned SY_S = ring_idx(SY_START, FIRST, SPAN) % LEN;
    localparam int unsigned SY_E = ring_idx(SY_END, FIRST, SPAN) % LEN;

    logic [W-1:0] cnt_q, cnt_d, idx_c;
    logic         blank_n_q, sync_n_q, sync_n_d;
    int unsigned  sy_s_c, sy_e_c;

    assign cnt_d = !step_i                 ? cnt_q :
                   (cnt_q == W'(LAST))     ? W'(FIRST) :
                                             cnt_q + W'(1);
    assign idx_c = cnt_d - W'(FIRST);

    assign blank_n_nxt_c_o = !in_window(32'(idx_c), BL_S, BL_E);

    // Sync window bounds follow the offset around the ring
    always_comb begin
        sy_s_c   = mod_add(SY_S, int'(ofs_i), LEN);
        sy_e_c   = mod_add(SY_E, int'(ofs_i), LEN);
        sync_n_d = !in_window(32'(idx_c), sy_s_c, sy_e_c);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q     <= W'(FIRST);
            blank_n_q <= 1'b0;
            sync_n_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            if (upd_i) begin
                blank_n_q <= blank_n_nxt_c_o;
                sync_n_q  <= sync_n_d;
            end
        end
    end

    assign cnt_nxt_c_o = cnt_d;
    assign cnt_o       = cnt_q;
    assign blank_n_o   = blank_n_q;
    assign sync_n_o    = sync_n_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel clock-enable, H/V axes, frame-shadowed sync
// offsets, flipped counts and line/frame strobes.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned HCNT_W     = DEF_HCNT_W,
    parameter int unsigned H_TOTAL    = DEF_H_TOTAL,
    parameter int unsigned H_BL_START = DEF_H_BL_START,
    parameter int unsigned H_BL_END   = DEF_H_BL_END,
    parameter int unsigned H_SY_START = DEF_H_SY_START,
    parameter int unsigned H_SY_END   = DEF_H_SY_END,
    parameter int unsigned V_INC_H    = DEF_V_INC_H,
    parameter int unsigned VCNT_W     = DEF_VCNT_W,
    parameter int unsigned V_FIRST    = DEF_V_FIRST,
    parameter int unsigned V_LAST     = DEF_V_LAST,
    parameter int unsigned V_BL_START = DEF_V_BL_START,
    parameter int unsigned V_BL_END   = DEF_V_BL_END,
    parameter int unsigned V_SY_START = DEF_V_SY_START,
    parameter int unsigned V_SY_END   = DEF_V_SY_END,
    parameter int unsigned OFS_W      = DEF_OFS_W
) (
    input  logic                    I_CLK,
    input  logic                    I_RST_n,
    input  logic                    I_HFLIP,
    input  logic                    I_VFLIP,
    input  logic signed [OFS_W-1:0] I_H_OFFSET,
    input  logic signed [OFS_W-1:0] I_V_OFFSET,
    output logic                    O_CE,
    output logic [HCNT_W-1:0]       O_H_CNT,
    output logic [VCNT_W-1:0]       O_V_CNT,
    output logic [HCNT_W-1:0]       O_HF_CNT,
    output logic [VCNT_W-1:0]       O_VF_CNT,
    output logic                    O_H_BLANKn,
    output logic                    O_V_BLANKn,
    output logic                    O_C_BLANKn,
    output logic                    O_H_SYNCn,
    output logic                    O_V_SYNCn,
    output logic                    O_LINE_START,
    output logic                    O_FRAME_START
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]        div_q, div_d;
    logic                    adv_c, v_step_c;
    logic                    ce_q, line_q, line_d, frame_q, frame_c;
    logic                    c_blank_n_q, c_blank_n_d;
    logic signed [OFS_W-1:0] hofs_q, hofs_d, vofs_q, vofs_d;
    logic [HCNT_W-1:0]       h_cnt, h_nxt;
    logic [VCNT_W-1:0]       v_cnt, v_nxt;
    logic                    h_bl_nxt, v_bl_nxt;

    // Counters move on the edge that raises O_CE, so every output lines up with it
    assign adv_c    = (div_q == DIV_W'(CLK_DIV - 2));
    assign v_step_c = adv_c && (h_cnt == HCNT_W'(V_INC_H));

    always_comb begin
        div_d       = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
        line_d      = adv_c && (h_nxt == '0);
        frame_c     = line_d && (v_nxt == VCNT_W'(V_FIRST));
        hofs_d      = frame_c ? I_H_OFFSET : hofs_q;
        vofs_d      = frame_c ? I_V_OFFSET : vofs_q;
        c_blank_n_d = adv_c ? (h_bl_nxt && v_bl_nxt) : c_blank_n_q;
    end

    always_ff @(posedge I_CLK or negedge I_RST_n) begin
        if (!I_RST_n) begin
            div_q       <= '0;
            ce_q        <= 1'b0;
            line_q      <= 1'b0;
            frame_q     <= 1'b0;
            c_blank_n_q <= 1'b0;
            hofs_q      <= '0;
            vofs_q      <= '0;
        end else begin
            div_q       <= div_d;
            ce_q        <= adv_c;
            line_q      <= line_d;
            frame_q     <= frame_c;
            c_blank_n_q <= c_blank_n_d;
            hofs_q      <= hofs_d;
            vofs_q      <= vofs_d;
        end
    end

    // Axes see the freshly latched offset on the frame-start edge itself
    video_timing_axis #(
        .W(HCNT_W), .FIRST(0), .LAST(H_TOTAL - 1),
        .BL_START(H_BL_START), .BL_END(H_BL_END),
        .SY_START(H_SY_START), .SY_END(H_SY_END), .OFS_W(OFS_W)
    ) u_h_axis (
        .clk_i(I_CLK), .rst_n_i(I_RST_n), .step_i(adv_c), .upd_i(adv_c),
        .ofs_i(hofs_d), .cnt_o(h_cnt), .cnt_nxt_c_o(h_nxt),
        .blank_n_o(O_H_BLANKn), .blank_n_nxt_c_o(h_bl_nxt), .sync_n_o(O_H_SYNCn)
    );

    video_timing_axis #(
        .W(VCNT_W), .FIRST(V_FIRST), .LAST(V_LAST),
        .BL_START(V_BL_START), .BL_END(V_BL_END),
        .SY_START(V_SY_START), .SY_END(V_SY_END), .OFS_W(OFS_W)
    ) u_v_axis (
        .clk_i(I_CLK), .rst_n_i(I_RST_n), .step_i(v_step_c), .upd_i(adv_c),
        .ofs_i(vofs_d), .cnt_o(v_cnt), .cnt_nxt_c_o(v_nxt),
        .blank_n_o(O_V_BLANKn), .blank_n_nxt_c_o(v_bl_nxt), .sync_n_o(O_V_SYNCn)
    );

    assign O_CE          = ce_q;
    assign O_H_CNT       = h_cnt;
    assign O_V_CNT       = v_cnt;
    assign O_HF_CNT      = h_cnt ^ {HCNT_W{I_HFLIP}};
    assign O_VF_CNT      = v_cnt ^ {VCNT_W{I_VFLIP}};
    assign O_C_BLANKn    = c_blank_n_q;
    assign O_LINE_START  = line_q;
    assign O_FRAME_START = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen on a small wrapping raster, checked every
// clock against an arithmetic model driven by the count of elapsed pixel ticks.
module tb_video_timing_gen;

    localparam int unsigned CD    = 3;
    localparam int unsigned HW    = 6;
    localparam int unsigned HT    = 40;
    localparam int unsigned HBS   = 28;
    localparam int unsigned HBE   = 4;
    localparam int unsigned HSS   = 30;
    localparam int unsigned HSE   = 36;
    localparam int unsigned VINC  = 31;
    localparam int unsigned VW    = 5;
    localparam int unsigned VF    = 28;
    localparam int unsigned VL    = 9;
    localparam int unsigned VBS   = 7;
    localparam int unsigned VBE   = 30;
    localparam int unsigned VSS   = 28;
    localparam int unsigned VSE   = 31;
    localparam int unsigned OW    = 5;
    localparam int unsigned VSPAN = 1 << VW;
    localparam int unsigned LEN   = ((VL + VSPAN - VF) % VSPAN) + 1;
    localparam int unsigned HMASK = (1 << HW) - 1;
    localparam int unsigned VMASK = VSPAN - 1;
    localparam int unsigned FRAME = HT * LEN * CD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hflip = 1'b0;
    logic vflip = 1'b0;
    logic signed [OW-1:0] hofs = '0;
    logic signed [OW-1:0] vofs = '0;
    logic          ce, hb, vb, cb, hs, vs, ls, fs;
    logic [HW-1:0] hcnt, hfcnt;
    logic [VW-1:0] vcnt, vfcnt;

    always #5 clk = ~clk;

    video_timing_gen #(
        .CLK_DIV(CD), .HCNT_W(HW), .H_TOTAL(HT), .H_BL_START(HBS), .H_BL_END(HBE),
        .H_SY_START(HSS), .H_SY_END(HSE), .V_INC_H(VINC), .VCNT_W(VW), .V_FIRST(VF),
        .V_LAST(VL), .V_BL_START(VBS), .V_BL_END(VBE), .V_SY_START(VSS),
        .V_SY_END(VSE), .OFS_W(OW)
    ) dut (
        .I_CLK(clk), .I_RST_n(rst_n), .I_HFLIP(hflip), .I_VFLIP(vflip),
        .I_H_OFFSET(hofs), .I_V_OFFSET(vofs),
        .O_CE(ce), .O_H_CNT(hcnt), .O_V_CNT(vcnt), .O_HF_CNT(hfcnt), .O_VF_CNT(vfcnt),
        .O_H_BLANKn(hb), .O_V_BLANKn(vb), .O_C_BLANKn(cb),
        .O_H_SYNCn(hs), .O_V_SYNCn(vs), .O_LINE_START(ls), .O_FRAME_START(fs)
    );

    int          errors = 0;
    int          checks = 0;
    int unsigned edges  = 0;
    int unsigned p_prev = 0;
    int          eff_h  = 0;
    int          eff_v  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edges);
        end
    endtask

    function automatic int unsigned wmod(input int a, input int unsigned n);
        int r;
        r = a % int'(n);
        if (r < 0) r = r + int'(n);
        return unsigned'(r);
    endfunction

    // Ordinal window test: distance from start is shorter than the window length
    function automatic bit inwin(input int unsigned x, input int unsigned s,
                                 input int unsigned e, input int unsigned n);
        return wmod(int'(x) - int'(s), n) < wmod(int'(e) - int'(s), n);
    endfunction

    task automatic check_reset();
        chk("rst_ce", 32'(ce), 0);
        chk("rst_h_cnt", 32'(hcnt), 0);
        chk("rst_v_cnt", 32'(vcnt), VF);
        chk("rst_hf_cnt", 32'(hfcnt), hflip ? HMASK : 0);
        chk("rst_vf_cnt", 32'(vfcnt), vflip ? (VF ^ VMASK) : VF);
        chk("rst_h_blank", 32'(hb), 0);
        chk("rst_v_blank", 32'(vb), 0);
        chk("rst_c_blank", 32'(cb), 0);
        chk("rst_h_sync", 32'(hs), 1);
        chk("rst_v_sync", 32'(vs), 1);
        chk("rst_line", 32'(ls), 0);
        chk("rst_frame", 32'(fs), 0);
    endtask

    task automatic step_check();
        int unsigned p, h, nadv, l, v, vs_nom, ve_nom;
        bit tick, e_hb, e_vb, e_hs, e_vs, e_ls, e_fs;
        p    = (edges + 1) / CD;
        tick = (p != p_prev);
        p_prev = p;
        h    = p % HT;
        nadv = (p + HT - 1 - VINC) / HT;
        l    = nadv % LEN;
        v    = (VF + l) % VSPAN;
        e_ls = tick && (h == 0);
        e_fs = e_ls && (l == 0);
        if (e_fs) begin
            eff_h = int'(hofs);
            eff_v = int'(vofs);
        end
        vs_nom = wmod(int'(VSS) - int'(VF), VSPAN);
        ve_nom = wmod(int'(VSE) - int'(VF), VSPAN);
        if (p == 0) begin
            e_hb = 0; e_vb = 0; e_hs = 1; e_vs = 1;
        end else begin
            e_hb = !inwin(h, HBS, HBE, HT);
            e_vb = !inwin(l, wmod(int'(VBS) - int'(VF), VSPAN),
                          wmod(int'(VBE) - int'(VF), VSPAN), LEN);
            e_hs = !inwin(h, wmod(int'(HSS) + eff_h, HT), wmod(int'(HSE) + eff_h, HT), HT);
            e_vs = !inwin(l, wmod(int'(vs_nom) + eff_v, LEN), wmod(int'(ve_nom) + eff_v, LEN), LEN);
        end
        chk("ce", 32'(ce), 32'(edges % CD == CD - 1));
        chk("h_cnt", 32'(hcnt), h);
        chk("v_cnt", 32'(vcnt), v);
        chk("hf_cnt", 32'(hfcnt), hflip ? (h ^ HMASK) : h);
        chk("vf_cnt", 32'(vfcnt), vflip ? (v ^ VMASK) : v);
        chk("h_blank", 32'(hb), 32'(e_hb));
        chk("v_blank", 32'(vb), 32'(e_vb));
        chk("c_blank", 32'(cb), 32'(e_hb && e_vb));
        chk("h_sync", 32'(hs), 32'(e_hs));
        chk("v_sync", 32'(vs), 32'(e_vs));
        chk("line_start", 32'(ls), 32'(e_ls));
        chk("frame_start", 32'(fs), 32'(e_fs));
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            edges++;
            #1;
            step_check();
            hflip = 1'($urandom_range(0, 1));
            vflip = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) hofs = OW'($urandom_range(0, (1 << OW) - 1));
            if ($urandom_range(0, 99) == 0) vofs = OW'($urandom_range(0, (1 << OW) - 1));
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        edges  = 0;
        p_prev = 0;
        eff_h  = 0;
        eff_v  = 0;
    endtask

    initial begin
        hofs = 5'sd3;
        vofs = -5'sd2;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        release_reset();
        run(20 * FRAME + $urandom_range(1, 500));
        // Asynchronous reset well away from a clock edge
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset();
        hofs = -5'sd16;
        vofs = 5'sd15;
        release_reset();
        run(5 * FRAME);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
